// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per clock.
// Optional DIV_EARLY_EXIT_EN: finish in two cycles when dividend < divisor.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_short;
  logic             r_dbz_cap;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;
  logic             w_accept;
  logic             w_div0;
  logic             w_short;
  logic [WIDTH:0]   w_a_sh;
  logic [WIDTH-1:0] w_sub;
  logic             w_fit;

  assign w_div0 = (divisor == '0);
`ifdef DIV_EARLY_EXIT_EN
  assign w_short = w_div0 || (dividend < divisor);
`else
  assign w_short = w_div0;
`endif

  // The partial remainder stays below the divisor, so it is held in WIDTH bits;
  // only the shifted value needs the extra bit for the compare.
  assign w_a_sh = {r_a, r_q[WIDTH-1]};
  assign w_fit  = (w_a_sh >= {1'b0, r_d});
  assign w_sub  = w_a_sh[WIDTH-1:0] - r_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == CW'(1)) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    w_accept = (r_state == S_IDLE) && start;
  end

  // Short operations (zero divisor, early exit) preload their answer and spend
  // a single CALC cycle without touching the accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_short   <= 1'b0;
      r_dbz_cap <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_d       <= divisor;
        r_cnt     <= w_short ? CW'(1) : CW'(WIDTH);
        r_short   <= w_short;
        r_dbz_cap <= w_div0;
        r_a       <= w_short ? dividend : '0;
        r_q       <= w_div0 ? '1 : (w_short ? '0 : dividend);
        r_quot    <= '0;
        r_rem     <= '0;
        r_dbz     <= 1'b0;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt - CW'(1);
        if (!r_short) begin
          r_a <= w_fit ? w_sub : w_a_sh[WIDTH-1:0];
          r_q <= {r_q[WIDTH-2:0], w_fit};
        end
      end else if (r_state == S_FIN) begin
        r_quot <= r_q;
        r_rem  <= r_a;
        r_dbz  <= r_dbz_cap;
        r_done <= 1'b1;
      end
    end
  end

  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized and directed checks of seq_divider against a transaction model.
module tb_seq_divider;
  localparam int W = 4;
`ifdef DIV_EARLY_EXIT_EN
  localparam int EE_LAT = 3;
`else
  localparam int EE_LAT = 6;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Transaction model: an accepted operation finishes a fixed number of edges later
  // with results taken straight from integer division.
  bit m_busy, m_done, m_dbz, p_dbz;
  int m_q, m_r, p_q, p_r, m_left;

  function automatic int edges_of(input int a, input int b);
`ifdef DIV_EARLY_EXIT_EN
    if (b == 0 || a < b) return 2;
`else
    if (b == 0) return 2;
`endif
    return W + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_dbz = 0; m_q = 0; m_r = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; m_dbz = p_dbz;
        end
      end else if (start) begin
        m_busy = 1; m_q = 0; m_r = 0; m_dbz = 0;
        m_left = edges_of(int'(dividend), int'(divisor));
        if (divisor == 0) begin
          p_q = (1 << W) - 1; p_r = int'(dividend); p_dbz = 1;
        end else begin
          p_q = int'(dividend) / int'(divisor); p_r = int'(dividend) % int'(divisor); p_dbz = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
    chk("div_by_zero", div_by_zero, m_dbz);
  end

  task automatic launch(input int a, input int b);
    start = 1'b1; dividend = W'(a); divisor = W'(b);
    @(negedge clk);
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
  endtask

  task automatic wait_done(input int l0, output int lat);
    lat = l0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      n_total++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", lat);
    end
  endtask

  task automatic do_op(input int a, input int b, output int lat);
    @(negedge clk);
    launch(a, b);
    wait_done(1, lat);
  endtask

  initial begin
    int lat;
    bit saw;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_q", quotient, 0);
    chk("post_rst_busy", busy, 0);

    do_op(13, 3, lat);
    chk("basic_lat", lat, 6);
    chk("basic_q", quotient, 4);
    chk("basic_r", remainder, 1);
    chk("basic_dbz", div_by_zero, 0);

    do_op(9, 0, lat);
    chk("dz_lat", lat, 3);
    chk("dz_q", quotient, 15);
    chk("dz_r", remainder, 9);
    chk("dz_dbz", div_by_zero, 1);

    @(negedge clk);
    launch(15, 1);
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, lat);
    chk("busy_ign_lat", lat, 6);
    chk("busy_ign_q", quotient, 15);
    chk("busy_ign_r", remainder, 0);
    launch(7, 2);
    wait_done(1, lat);
    chk("b2b_lat", lat, 6);
    chk("b2b_q", quotient, 3);
    chk("b2b_r", remainder, 1);

    @(negedge clk);
    launch(14, 5);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    chk("abort_no_done", saw, 0);
    do_op(14, 5, lat);
    chk("after_abort_q", quotient, 2);
    chk("after_abort_r", remainder, 4);

    do_op(2, 7, lat);
    chk("ee_lat", lat, EE_LAT);
    chk("ee_q", quotient, 0);
    chk("ee_r", remainder, 2);

    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        do_op(a, b, lat);
        chk("exh_lat", lat, edges_of(a, b) + 1);
      end
    end

    // Free-running random traffic, including start pulses while busy.
    repeat (1500) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      dividend = W'($urandom);
      divisor = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
